// File: rtl/ca_ps_pkg.sv
// Shared types for the CA power-supply sequencer: state and fault encodings,
// the per-state drive pattern and a small sizing helper.
package ca_ps_pkg;

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_PRECHG = 3'd1,
      S_RAMP   = 3'd2,
      S_ON     = 3'd3,
      S_DISCH  = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      F_NONE    = 3'd0,
      F_OC      = 3'd1,
      F_UV      = 3'd2,
      F_PERM    = 3'd3,
      F_RAMP_TO = 3'd4
   } fault_t;

   typedef struct packed {
      logic contactor;
      logic ramp_en;
      logic ca_ps_act;
      logic fault;
   } drive_t;

   // Output pattern driven while the sequencer sits in a given state.
   function automatic drive_t state_drive(input state_t s);
      drive_t d;
      case (s)
         S_OFF:    d = 4'b0000;
         S_PRECHG: d = 4'b1000;
         S_RAMP:   d = 4'b1100;
         S_ON:     d = 4'b1110;
         S_DISCH:  d = 4'b1000;
         S_FAULT:  d = 4'b0001;
         default:  d = 4'b0000;
      endcase
      return d;
   endfunction

   // Largest of three cycle counts; sizes the shared phase timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/ca_ps_sequencer_input_filter.sv
// Synchronizer chain followed by a consecutive-sample debounce filter for one
// asynchronous, level-type card signal. The filtered output only flips after
// DEBOUNCE consecutive synced samples disagree with it.
module input_filter #(
   parameter int   SYNC_STAGES = 2,
   parameter int   DEBOUNCE    = 4,
   parameter logic RESET_VAL   = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic filt
);

   localparam int DB_W = $clog2(DEBOUNCE + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [DB_W-1:0]        cnt;
   logic                   synced;

   assign synced = sync[SYNC_STAGES-1];

   // Metastability chain: stage 0 samples the raw pin, later stages shift it along.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= {SYNC_STAGES{RESET_VAL}};
      end else begin
         sync[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync[i] <= sync[i-1];
         end
      end
   end

   // Count consecutive disagreeing samples; adopt the new level on the last one.
   always_ff @(posedge clk) begin
      if (reset) begin
         filt <= RESET_VAL;
         cnt  <= {DB_W{1'b0}};
      end else if (synced == filt) begin
         cnt  <= {DB_W{1'b0}};
      end else if (cnt == DB_LAST) begin
         filt <= synced;
         cnt  <= {DB_W{1'b0}};
      end else begin
         cnt  <= cnt + DB_W'(1);
      end
   end

endmodule

// File: rtl/ca_ps_sequencer.sv
// Supply-side responder to the RPSC card CA permission interface. Sequences the
// contactor through precharge, ramp, steady-on and discharge, reports CA_PS_ACT
// back to the card and latches the first fault cause until it is cleared.
module ca_ps_sequencer #(
   parameter int SYNC_STAGES   = 2,
   parameter int DEBOUNCE      = 4,
   parameter int PRECHARGE_CYC = 8,
   parameter int RAMP_TIMEOUT  = 16,
   parameter int DISCHARGE_CYC = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_ca_on_perm_n,
   input  logic       i_ca_high_n,
   input  logic       i_u_ca_low_n,
   input  logic       i_ps_ready,
   input  logic       cmd_on,
   input  logic       cmd_off,
   input  logic       fault_clr,
   output logic       o_ca_ps_act,
   output logic       o_contactor,
   output logic       o_ramp_en,
   output logic       o_fault,
   output logic [2:0] o_fault_code,
   output logic [2:0] o_state
);

   import ca_ps_pkg::*;

   localparam int CNT_W = $clog2(max3(PRECHARGE_CYC, RAMP_TIMEOUT, DISCHARGE_CYC)) + 1;
   localparam logic [CNT_W-1:0] LD_PRE  = CNT_W'(PRECHARGE_CYC - 1);
   localparam logic [CNT_W-1:0] LD_RAMP = CNT_W'(RAMP_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LD_DIS  = CNT_W'(DISCHARGE_CYC - 1);

   logic perm_n;
   logic high_n;
   logic u_low_n;
   logic [SYNC_STAGES-1:0] ready_sync;

   logic perm;
   logic oc;
   logic uv;
   logic ps_ready;
   logic cnt_zero;

   state_t           state;
   state_t           nxt_state;
   fault_t           fault_code;
   fault_t           nxt_code;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nxt_cnt;
   drive_t           drive;

   input_filter #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b1)
   ) u_perm_filter (
      .clk(clk), .reset(reset), .raw(i_ca_on_perm_n), .filt(perm_n)
   );

   input_filter #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b1)
   ) u_high_filter (
      .clk(clk), .reset(reset), .raw(i_ca_high_n), .filt(high_n)
   );

   input_filter #(
      .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .RESET_VAL(1'b1)
   ) u_ulow_filter (
      .clk(clk), .reset(reset), .raw(i_u_ca_low_n), .filt(u_low_n)
   );

   // ps_ready comes from the supply's own regulator, so it is synchronized but not debounced.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_sync <= {SYNC_STAGES{1'b0}};
      end else begin
         ready_sync[0] <= i_ps_ready;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            ready_sync[i] <= ready_sync[i-1];
         end
      end
   end

   assign perm     = ~perm_n;
   assign oc       = ~high_n;
   assign uv       = ~u_low_n;
   assign ps_ready = ready_sync[SYNC_STAGES-1];
   assign cnt_zero = (cnt == {CNT_W{1'b0}});

   // Next-state and fault-cause selection; fault checks take precedence over cmd_off.
   always_comb begin
      nxt_state = state;
      nxt_code  = fault_code;
      case (state)
         S_OFF: begin
            if (cmd_on && !cmd_off && perm) nxt_state = S_PRECHG;
            else                            nxt_state = S_OFF;
         end
         S_PRECHG: begin
            if (oc) begin
               nxt_state = S_FAULT;
               nxt_code  = F_OC;
            end else if (!perm) begin
               nxt_state = S_FAULT;
               nxt_code  = F_PERM;
            end else if (cmd_off) begin
               nxt_state = S_DISCH;
            end else if (cnt_zero) begin
               nxt_state = S_RAMP;
            end else begin
               nxt_state = S_PRECHG;
            end
         end
         S_RAMP: begin
            if (oc) begin
               nxt_state = S_FAULT;
               nxt_code  = F_OC;
            end else if (!perm) begin
               nxt_state = S_FAULT;
               nxt_code  = F_PERM;
            end else if (cmd_off) begin
               nxt_state = S_DISCH;
            end else if (ps_ready) begin
               // ready arriving in the expiry cycle still counts as success
               nxt_state = S_ON;
            end else if (cnt_zero) begin
               nxt_state = S_FAULT;
               nxt_code  = F_RAMP_TO;
            end else begin
               nxt_state = S_RAMP;
            end
         end
         S_ON: begin
            if (oc) begin
               nxt_state = S_FAULT;
               nxt_code  = F_OC;
            end else if (uv) begin
               nxt_state = S_FAULT;
               nxt_code  = F_UV;
            end else if (!perm) begin
               nxt_state = S_FAULT;
               nxt_code  = F_PERM;
            end else if (cmd_off) begin
               nxt_state = S_DISCH;
            end else begin
               nxt_state = S_ON;
            end
         end
         S_DISCH: begin
            // discharge always runs to completion, whatever the card reports
            if (cnt_zero) nxt_state = S_OFF;
            else          nxt_state = S_DISCH;
         end
         S_FAULT: begin
            if (fault_clr && !cmd_on) begin
               nxt_state = S_OFF;
               nxt_code  = F_NONE;
            end else begin
               nxt_state = S_FAULT;
            end
         end
         default: begin
            nxt_state = S_OFF;
            nxt_code  = F_NONE;
         end
      endcase
   end

   // Shared phase timer: reloaded with N-1 on every state entry, then counts down to 0.
   always_comb begin
      nxt_cnt = cnt;
      if (nxt_state != state) begin
         case (nxt_state)
            S_PRECHG: nxt_cnt = LD_PRE;
            S_RAMP:   nxt_cnt = LD_RAMP;
            S_DISCH:  nxt_cnt = LD_DIS;
            default:  nxt_cnt = {CNT_W{1'b0}};
         endcase
      end else if (!cnt_zero) begin
         nxt_cnt = cnt - CNT_W'(1);
      end else begin
         nxt_cnt = cnt;
      end
   end

   // State, timer, latched fault cause and the drive pattern of the new state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_OFF;
         fault_code <= F_NONE;
         cnt        <= {CNT_W{1'b0}};
         drive      <= 4'b0000;
      end else begin
         state      <= nxt_state;
         fault_code <= nxt_code;
         cnt        <= nxt_cnt;
         drive      <= state_drive(nxt_state);
      end
   end

   assign o_contactor  = drive.contactor;
   assign o_ramp_en    = drive.ramp_en;
   assign o_ca_ps_act  = drive.ca_ps_act;
   assign o_fault      = drive.fault;
   assign o_fault_code = fault_code;
   assign o_state      = state;

endmodule

// File: tb/tb_ca_ps_sequencer.sv
// Self-checking bench for ca_ps_sequencer: a directed walk through the main
// scenarios followed by randomized input levels, every cycle compared against
// a behavioural model built from sample histories and time-in-state counts.
module tb_ca_ps_sequencer;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int HL   = SYNC + DEB;
   localparam int PRE  = 8;
   localparam int RTO  = 16;
   localparam int DIS  = 8;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       perm_n    = 1'b1;
   logic       high_n    = 1'b1;
   logic       ulow_n    = 1'b1;
   logic       ps_ready  = 1'b0;
   logic       cmd_on    = 1'b0;
   logic       cmd_off   = 1'b0;
   logic       fault_clr = 1'b0;
   logic       act;
   logic       contactor;
   logic       ramp_en;
   logic       fault;
   logic [2:0] code;
   logic [2:0] state;

   ca_ps_sequencer dut (
      .clk(clk), .reset(reset),
      .i_ca_on_perm_n(perm_n), .i_ca_high_n(high_n), .i_u_ca_low_n(ulow_n),
      .i_ps_ready(ps_ready), .cmd_on(cmd_on), .cmd_off(cmd_off), .fault_clr(fault_clr),
      .o_ca_ps_act(act), .o_contactor(contactor), .o_ramp_en(ramp_en),
      .o_fault(fault), .o_fault_code(code), .o_state(state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_state = 0;
   int m_code  = 0;
   int m_cyc   = 0;
   logic f_perm = 1'b1;
   logic f_high = 1'b1;
   logic f_ulow = 1'b1;
   logic [HL-1:0]   h_perm = '1;
   logic [HL-1:0]   h_high = '1;
   logic [HL-1:0]   h_ulow = '1;
   logic [SYNC-1:0] h_rdy  = '0;

   // {contactor, ramp_en, act, fault} per state, straight from the output table
   logic [3:0] drive_tab [6] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1000, 4'b0001};

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // A filtered level flips once the DEB raw samples taken SYNC..HL-1 edges ago all disagree with it.
   function automatic logic filt_next(input logic cur, input logic [HL-1:0] h);
      logic [DEB-1:0] win;
      win = h[HL-1:SYNC];
      if (cur && win == '0)        return 1'b0;
      else if (!cur && win == '1)  return 1'b1;
      else                         return cur;
   endfunction

   task automatic model_step();
      logic perm, oc, uv, rdy;
      int nx;
      if (reset) begin
         m_state = 0; m_code = 0; m_cyc = 0;
         f_perm = 1'b1; f_high = 1'b1; f_ulow = 1'b1;
         h_perm = '1; h_high = '1; h_ulow = '1; h_rdy = '0;
      end else begin
         perm = !f_perm; oc = !f_high; uv = !f_ulow;
         rdy  = h_rdy[SYNC-1];
         nx   = m_state;
         m_cyc++;
         case (m_state)
            0: if (cmd_on && !cmd_off && perm) nx = 1;
            1, 2, 3: begin
               if (oc)                          begin nx = 5; m_code = 1; end
               else if (m_state == 3 && uv)     begin nx = 5; m_code = 2; end
               else if (!perm)                  begin nx = 5; m_code = 3; end
               else if (cmd_off)                nx = 4;
               else if (m_state == 1 && m_cyc == PRE) nx = 2;
               else if (m_state == 2 && rdy)    nx = 3;
               else if (m_state == 2 && m_cyc == RTO) begin nx = 5; m_code = 4; end
            end
            4: if (m_cyc == DIS) nx = 0;
            5: if (fault_clr && !cmd_on) begin nx = 0; m_code = 0; end
            default: nx = 0;
         endcase
         if (nx != m_state) m_cyc = 0;
         m_state = nx;
         h_perm = {h_perm[HL-2:0], perm_n};
         h_high = {h_high[HL-2:0], high_n};
         h_ulow = {h_ulow[HL-2:0], ulow_n};
         h_rdy  = {h_rdy[SYNC-2:0], ps_ready};
         f_perm = filt_next(f_perm, h_perm);
         f_high = filt_next(f_high, h_high);
         f_ulow = filt_next(f_ulow, h_ulow);
      end
   endtask

   task automatic cyc();
      logic [3:0] d;
      @(posedge clk);
      model_step();
      #1;
      d = drive_tab[m_state];
      check("state",     {5'd0, state},     8'(m_state));
      check("contactor", {7'd0, contactor}, {7'd0, d[3]});
      check("ramp_en",   {7'd0, ramp_en},   {7'd0, d[2]});
      check("ca_ps_act", {7'd0, act},       {7'd0, d[1]});
      check("fault",     {7'd0, fault},     {7'd0, d[0]});
      check("code",      {5'd0, code},      8'(m_code));
   endtask

   int hold_perm = 0, hold_high = 0, hold_ulow = 0, hold_rdy = 0;
   int hold_on = 0, hold_off = 0, hold_clr = 0;

   initial begin
      // reset and normal power-up
      reset = 1'b1; cyc(); cyc();
      check("d_reset_state", {5'd0, state}, 8'd0);
      reset = 1'b0; perm_n = 1'b0;
      repeat (6) cyc();
      cmd_on = 1'b1; cyc();
      check("d_prechg_entry", {5'd0, state}, 8'd1);
      repeat (7) cyc();
      check("d_prechg_last", {5'd0, state}, 8'd1);
      cyc();
      check("d_ramp_entry", {5'd0, state}, 8'd2);
      repeat (4) cyc();
      ps_ready = 1'b1; cyc(); cyc();
      check("d_act_not_yet", {7'd0, act}, 8'd0);
      cyc();
      check("d_act_on", {7'd0, act}, 8'd1);

      // overcurrent glitch rejected, then held overcurrent faults
      high_n = 1'b0; repeat (3) cyc(); high_n = 1'b1;
      repeat (10) cyc();
      check("d_glitch_ignored", {7'd0, fault}, 8'd0);
      high_n = 1'b0; repeat (6) cyc();
      check("d_oc_before", {7'd0, fault}, 8'd0);
      cyc();
      check("d_oc_fault", {5'd0, state}, 8'd5);
      check("d_oc_code", {5'd0, code}, 8'd1);
      perm_n = 1'b1; repeat (10) cyc();
      check("d_code_holds", {5'd0, code}, 8'd1);

      // clear is refused while cmd_on is high
      high_n = 1'b1; perm_n = 1'b0; fault_clr = 1'b1;
      repeat (8) cyc();
      check("d_clr_refused", {5'd0, state}, 8'd5);
      cmd_on = 1'b0; cyc();
      check("d_clr_state", {5'd0, state}, 8'd0);
      check("d_clr_code", {5'd0, code}, 8'd0);
      fault_clr = 1'b0;

      // permission loss in ON
      cmd_on = 1'b1; repeat (12) cyc();
      check("d_on_again", {5'd0, state}, 8'd3);
      cmd_on = 1'b0; perm_n = 1'b1; repeat (7) cyc();
      check("d_perm_code", {5'd0, code}, 8'd3);
      perm_n = 1'b0; fault_clr = 1'b1; cyc(); fault_clr = 1'b0;

      // off request and simultaneous on/off in OFF
      cmd_on = 1'b1; repeat (20) cyc();
      cmd_off = 1'b1; cyc();
      check("d_disch_entry", {5'd0, state}, 8'd4);
      check("d_disch_contactor", {7'd0, contactor}, 8'd1);
      repeat (7) cyc();
      check("d_disch_last", {5'd0, state}, 8'd4);
      cyc();
      check("d_off_after_disch", {5'd0, state}, 8'd0);
      repeat (3) cyc();
      check("d_on_off_together", {5'd0, state}, 8'd0);
      cmd_off = 1'b0;

      // oc and perm loss together: oc wins
      repeat (12) cyc();
      cmd_on = 1'b0; high_n = 1'b0; perm_n = 1'b1; repeat (7) cyc();
      check("d_oc_over_perm", {5'd0, code}, 8'd1);
      high_n = 1'b1; perm_n = 1'b0; repeat (7) cyc();
      fault_clr = 1'b1; cyc(); fault_clr = 1'b0;

      // uv and perm loss together in ON: uv wins
      cmd_on = 1'b1; repeat (12) cyc();
      cmd_on = 1'b0; ulow_n = 1'b0; perm_n = 1'b1; repeat (7) cyc();
      check("d_uv_over_perm", {5'd0, code}, 8'd2);
      ulow_n = 1'b1; perm_n = 1'b0; ps_ready = 1'b0; repeat (7) cyc();
      fault_clr = 1'b1; cyc(); fault_clr = 1'b0;

      // ramp timeout
      cmd_on = 1'b1; repeat (24) cyc();
      check("d_ramp_last", {5'd0, state}, 8'd2);
      cyc();
      check("d_ramp_to_code", {5'd0, code}, 8'd4);
      check("d_ramp_to_contactor", {7'd0, contactor}, 8'd0);
      cmd_on = 1'b0; fault_clr = 1'b1; cyc(); fault_clr = 1'b0;

      // reset in RAMP, permission must re-qualify
      cmd_on = 1'b1; repeat (10) cyc();
      check("d_ramp_before_reset", {5'd0, state}, 8'd2);
      reset = 1'b1; cyc(); reset = 1'b0;
      check("d_midreset_state", {5'd0, state}, 8'd0);
      check("d_midreset_contactor", {7'd0, contactor}, 8'd0);
      repeat (6) cyc();
      check("d_requalify_wait", {5'd0, state}, 8'd0);
      cyc();
      check("d_requalify_go", {5'd0, state}, 8'd1);

      // randomized level-hold stimulus
      for (int n = 0; n < 6000; n++) begin
         if (hold_perm == 0) begin
            perm_n = ~perm_n;
            hold_perm = perm_n ? int'($urandom_range(12, 1)) : int'($urandom_range(150, 10));
         end else hold_perm--;
         if (hold_high == 0) begin
            high_n = ~high_n;
            hold_high = high_n ? int'($urandom_range(400, 30)) : int'($urandom_range(10, 1));
         end else hold_high--;
         if (hold_ulow == 0) begin
            ulow_n = ~ulow_n;
            hold_ulow = ulow_n ? int'($urandom_range(400, 30)) : int'($urandom_range(10, 1));
         end else hold_ulow--;
         if (hold_rdy == 0) begin
            ps_ready = ~ps_ready;
            hold_rdy = int'($urandom_range(24, 1));
         end else hold_rdy--;
         if (hold_on == 0) begin
            cmd_on = ~cmd_on;
            hold_on = int'($urandom_range(40, 1));
         end else hold_on--;
         if (hold_off == 0) begin
            cmd_off = ~cmd_off;
            hold_off = cmd_off ? int'($urandom_range(3, 1)) : int'($urandom_range(80, 5));
         end else hold_off--;
         if (hold_clr == 0) begin
            fault_clr = ~fault_clr;
            hold_clr = fault_clr ? int'($urandom_range(4, 1)) : int'($urandom_range(60, 5));
         end else hold_clr--;
         reset = ($urandom_range(599, 0) == 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ca_ps_sequencer.md
Name: ca_ps_sequencer

Overview:
Power-supply-side sequencer for the cathode/anode (CA) supply. It is the responder to the RPSC card's CA permission interface.
- Consumes the card's active-low CA_ON_PERM, I_CA_High and U_CA_Low signals.
- Drives CA_PS_ACT back to the card.
- Runs contactor precharge, ramp, steady-on and discharge phases, and latches the first fault.

Parameters:
SYNC_STAGES, 2, synchronizer flops on each asynchronous input
DEBOUNCE, 4, consecutive stable synced samples required to change a filtered input
PRECHARGE_CYC, 8, cycles spent in PRECHG
RAMP_TIMEOUT, 16, max cycles in RAMP without ps_ready
DISCHARGE_CYC, 8, cycles spent in DISCH

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_ca_on_perm_n  in  1  async; low = card grants CA permission
i_ca_high_n  in  1  async; low = overcurrent reported by card
i_u_ca_low_n  in  1  async; low = undervoltage reported by card
i_ps_ready  in  1  async; supply output reached setpoint
cmd_on  in  1  sync; request supply on (level)
cmd_off  in  1  sync; request supply off (level)
fault_clr  in  1  sync; clear latched fault
o_ca_ps_act  out  1  high = supply active; goes to card CA_PS_ACT input
o_contactor  out  1  main contactor close
o_ramp_en  out  1  ramp generator enable
o_fault  out  1  high while in FAULT
o_fault_code  out  3  latched fault cause
o_state  out  3  current state encoding

Behaviour:
- Reset state, applied on the next clk edge while reset=1, including mid-operation:
  - State = S_OFF; all outputs 0; o_fault_code = 0.
  - Filters reset to inactive: perm_n = 1, high_n = 1, u_low_n = 1.
  - Synchronizers reset to the inactive level. ps_ready resets to 0.
- Input filtering (perm_n, high_n, u_low_n):
  - Each input passes through SYNC_STAGES flops, then a debounce filter.
  - The filtered value changes exactly SYNC_STAGES+DEBOUNCE edges after a clean raw change (6 at defaults).
  - A glitch shorter than DEBOUNCE synced cycles is ignored.
- i_ps_ready is synchronized only; latency is SYNC_STAGES.
- Outputs are a pure function of the registered state (no combinational input-to-output path):

| State | o_contactor | o_ramp_en | o_ca_ps_act | o_fault | Code |
|---|---|---|---|---|---|
| S_OFF | 0 | 0 | 0 | 0 | 0 |
| S_PRECHG | 1 | 0 | 0 | 0 | 1 |
| S_RAMP | 1 | 1 | 0 | 0 | 2 |
| S_ON | 1 | 1 | 1 | 0 | 3 |
| S_DISCH | 1 | 0 | 0 | 0 | 4 |
| S_FAULT | 0 | 0 | 0 | 1 | 5 |

- Timing: one shared down-counter, width clog2(max param)+1, loaded with N-1 on state entry.
- Transitions (perm = filtered perm_n==0; oc = filtered high_n==0; uv = filtered u_low_n==0):
  - S_OFF: cmd_on & ~cmd_off & perm -> S_PRECHG. A simultaneous cmd_on and cmd_off stays in S_OFF.
  - S_PRECHG: fault check, then cmd_off -> S_DISCH; after exactly PRECHARGE_CYC cycles -> S_RAMP.
  - S_RAMP: fault check, then cmd_off -> S_DISCH; ps_ready -> S_ON.
    - No ps_ready within RAMP_TIMEOUT cycles -> S_FAULT, code RAMP_TO.
    - ps_ready in the expiry cycle wins: -> S_ON.
  - S_ON: fault check (uv also checked here), then cmd_off -> S_DISCH.
  - S_DISCH: exactly DISCHARGE_CYC cycles, then -> S_OFF. Faults are ignored; perm loss is ignored.
  - S_FAULT: fault_clr & ~cmd_on -> S_OFF and the code clears. fault_clr with cmd_on=1 is ignored.
- Fault check priority (highest first): oc (code 1) > uv (code 2, checked in S_ON only) > perm lost (code 3).
  - oc and perm lost are checked in S_PRECHG, S_RAMP and S_ON.
  - The code is latched on entry to S_FAULT and holds until cleared; a later fault never overwrites it.
- Perm loss in S_OFF has no effect.

Decomposition:
- Package ca_ps_pkg:
  - state_t enum (3-bit, encodings above).
  - fault_t enum: F_NONE=0, F_OC=1, F_UV=2, F_PERM=3, F_RAMP_TO=4.
- Sub-module input_filter, parameterized by SYNC_STAGES, DEBOUNCE and reset value; one instance per async input.

Test Plan:
- Normal sequence:
  - Stimulus: reset; perm_n=0; after 6 cycles raise cmd_on; raise ps_ready 5 cycles after RAMP entry.
  - Response: PRECHG for 8 cycles with contactor=1. RAMP with ramp_en=1. o_ca_ps_act=1 3 cycles after ps_ready (2 sync + 1 state edge).
- Ramp timeout: ps_ready held 0 -> S_FAULT after 16 RAMP cycles; o_fault=1, o_fault_code=4, all drive outputs 0.
- Overcurrent in ON:
  - Stimulus: i_ca_high_n pulsed low for 3 cycles.
  - Response: no fault (glitch rejected).
  - Stimulus: i_ca_high_n held low.
  - Response: S_FAULT 7 cycles after the edge, code=1. A subsequent perm loss leaves code=1.
- Permission loss and clear:
  - Stimulus: perm_n=1 in ON.
  - Response: code=3. fault_clr with cmd_on=1 stays in FAULT. fault_clr with cmd_on=0 -> S_OFF, code=0.
- Off request: cmd_off in ON -> S_DISCH for 8 cycles with contactor=1 and act=0, then S_OFF with contactor=0. cmd_on+cmd_off together in OFF -> stays OFF.
- Reset mid-RAMP: reset=1 for 1 cycle -> next edge state=0, all outputs 0, and perm must re-qualify (6 cycles) before cmd_on is honoured.
